// File: rtl/trigger_sequencer.sv
// trigger_sequencer
//   Multi-stage controller for a single trigger block. For each stage it loads
//   one config slot onto the trigger's cfg inputs, waits for a trigger_out
//   rising edge, then moves on to the next stage. When the last stage fires it
//   pulses seq_trig, waits out a holdoff, and then either rearms or goes idle.
//   While a stage above 0 is armed, an optional timeout restarts the sequence
//   from stage 0.
//
// Optional feature (compile-time macro SEQ_TRIG_COUNT_EN):
//   defined   : seq_trig_count counts seq_trig pulses and saturates at 16'hFFFF
//   undefined : seq_trig_count is tied to 0 and no counter is built
//
// Ports
//   clk, rst_n_sync        clock, asynchronous active-low reset
//   arm, abort             1-clk host pulses (abort has priority)
//   cfg_num_stages         index of the last stage (clamped to NUM_STAGES-1)
//   cfg_stage              NUM_STAGES packed slots of 24 bits:
//                          {lne, tb[2:0], c2[7:0], c1[7:0], type[2:0], pos}
//   cfg_timeout            inter-stage timeout in clks, 0 = disabled
//   cfg_holdoff            clks after the final trigger_out low before rearm
//   cfg_auto_rearm         1: restart at stage 0 after holdoff, 0: go idle
//   trigger_out            output of the trigger block
//   trg_cfg_*              config driven into the trigger block
//   seq_trig               1-clk pulse when the final stage fires
//   stage_idx, busy        current stage, state != IDLE
//   timeout_flag           sticky, cleared when arm is accepted
//   seq_trig_count         seq_trig pulse count (see macro above)
//
// state    | meaning
// ---------+----------------------------------------------------------------
// IDLE     | trigger disabled, waiting for arm
// LOAD     | one clk: copy slot[stage_idx] onto trg_cfg_*, reload timeout
// ARM      | waiting for a trigger_out rising edge (or a timeout)
// WAIT_LOW | stage advanced or timed out; wait for trigger_out low
// HOLDOFF  | final stage fired; wait for low, then count cfg_holdoff clks
module trigger_sequencer #(
  parameter int  NUM_STAGES = 4,
  parameter int  TO_W       = 24,
  parameter int  HO_W       = 16,
  localparam int STG_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n_sync,
  input  logic                     arm,
  input  logic                     abort,
  input  logic [STG_W-1:0]         cfg_num_stages,
  input  logic [NUM_STAGES*24-1:0] cfg_stage,
  input  logic [TO_W-1:0]          cfg_timeout,
  input  logic [HO_W-1:0]          cfg_holdoff,
  input  logic                     cfg_auto_rearm,
  input  logic                     trigger_out,
  output logic                     trg_cfg_enable,
  output logic                     trg_cfg_positive,
  output logic [2:0]               trg_cfg_type,
  output logic [7:0]               trg_cfg_count1,
  output logic [7:0]               trg_cfg_count2,
  output logic [2:0]               trg_cfg_time_base,
  output logic                     trg_cfg_longer_no_edge,
  output logic                     seq_trig,
  output logic [STG_W-1:0]         stage_idx,
  output logic                     busy,
  output logic                     timeout_flag,
  output logic [15:0]              seq_trig_count
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_ARM      = 3'd2;
  localparam logic [2:0] ST_WAIT_LOW = 3'd3;
  localparam logic [2:0] ST_HOLDOFF  = 3'd4;

  localparam logic [STG_W-1:0] STG_MAX = STG_W'(NUM_STAGES - 1);

  logic [2:0]       state;
  logic             trigger_out_q;
  logic             trig_rise;
  logic [STG_W-1:0] last_stage;
  logic [STG_W-1:0] num_clamped;
  logic [TO_W-1:0]  to_lat;
  logic [TO_W-1:0]  to_cnt;
  logic [HO_W-1:0]  ho_lat;
  logic [HO_W-1:0]  ho_cnt;
  logic             ho_low;
  logic [23:0]      slot;
  logic [23:0]      slot_arr [NUM_STAGES];

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_slot
    assign slot_arr[g] = cfg_stage[g*24 +: 24];
  end

  assign slot        = slot_arr[stage_idx];
  assign trig_rise   = trigger_out & ~trigger_out_q;
  assign busy        = (state != ST_IDLE);
  assign num_clamped = (int'(cfg_num_stages) > NUM_STAGES - 1) ? STG_MAX : cfg_num_stages;

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state                  <= ST_IDLE;
      trigger_out_q          <= 1'b0;
      stage_idx              <= '0;
      last_stage             <= '0;
      to_lat                 <= '0;
      to_cnt                 <= '0;
      ho_lat                 <= '0;
      ho_cnt                 <= '0;
      ho_low                 <= 1'b0;
      seq_trig               <= 1'b0;
      timeout_flag           <= 1'b0;
      trg_cfg_enable         <= 1'b0;
      trg_cfg_positive       <= 1'b0;
      trg_cfg_type           <= '0;
      trg_cfg_count1         <= '0;
      trg_cfg_count2         <= '0;
      trg_cfg_time_base      <= '0;
      trg_cfg_longer_no_edge <= 1'b0;
    end else begin
      trigger_out_q <= trigger_out;
      seq_trig      <= 1'b0;
      if (abort) begin
        state          <= ST_IDLE;
        stage_idx      <= '0;
        trg_cfg_enable <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (arm) begin
              timeout_flag   <= 1'b0;
              last_stage     <= num_clamped;
              to_lat         <= cfg_timeout;
              ho_lat         <= cfg_holdoff;
              stage_idx      <= '0;
              trg_cfg_enable <= 1'b1;
              state          <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            trg_cfg_longer_no_edge <= slot[23];
            trg_cfg_time_base      <= slot[22:20];
            trg_cfg_count2         <= slot[19:12];
            trg_cfg_count1         <= slot[11:4];
            trg_cfg_type           <= slot[3:1];
            trg_cfg_positive       <= slot[0];
            // down-counter expires at 0, i.e. on the cfg_timeout-th clk in ARM
            to_cnt                 <= to_lat - TO_W'(1);
            state                  <= ST_ARM;
          end
          ST_ARM: begin
            if (trig_rise) begin
              if (stage_idx == last_stage) begin
                seq_trig <= 1'b1;
                ho_cnt   <= ho_lat;
                ho_low   <= 1'b0;
                state    <= ST_HOLDOFF;
              end else begin
                stage_idx <= stage_idx + STG_W'(1);
                state     <= ST_WAIT_LOW;
              end
            end else if (stage_idx != '0 && to_lat != '0) begin
              if (to_cnt == '0) begin
                timeout_flag <= 1'b1;
                stage_idx    <= '0;
                state        <= ST_WAIT_LOW;
              end else begin
                to_cnt <= to_cnt - TO_W'(1);
              end
            end
          end
          ST_WAIT_LOW: begin
            if (!trigger_out) state <= ST_LOAD;
          end
          ST_HOLDOFF: begin
            // once trigger_out has been seen low, keep counting regardless of
            // further pulses so they cannot stretch the holdoff
            if (ho_low || !trigger_out) begin
              if (ho_cnt == '0) begin
                stage_idx      <= '0;
                trg_cfg_enable <= cfg_auto_rearm;
                state          <= cfg_auto_rearm ? ST_LOAD : ST_IDLE;
              end else begin
                ho_cnt <= ho_cnt - HO_W'(1);
                ho_low <= 1'b1;
              end
            end
          end
          default: begin
            state          <= ST_IDLE;
            stage_idx      <= '0;
            trg_cfg_enable <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SEQ_TRIG_COUNT_EN
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      seq_trig_count <= '0;
    end else if (seq_trig && seq_trig_count != 16'hFFFF) begin
      seq_trig_count <= seq_trig_count + 16'd1;
    end
  end
`else
  assign seq_trig_count = 16'd0;
`endif

endmodule

// File: tb/tb_trigger_sequencer.sv
module tb_trigger_sequencer;
  localparam int NS    = 4;
  localparam int STG_W = 2;

  logic             clk = 1'b0;
  logic             rst_n_sync = 1'b0;
  logic             arm = 1'b0;
  logic             abort = 1'b0;
  logic [STG_W-1:0] cfg_num_stages = '0;
  logic [NS*24-1:0] cfg_stage = '0;
  logic [23:0]      cfg_timeout = '0;
  logic [15:0]      cfg_holdoff = '0;
  logic             cfg_auto_rearm = 1'b0;
  logic             trigger_out = 1'b0;
  logic             trg_cfg_enable, trg_cfg_positive, trg_cfg_longer_no_edge;
  logic [2:0]       trg_cfg_type, trg_cfg_time_base;
  logic [7:0]       trg_cfg_count1, trg_cfg_count2;
  logic             seq_trig, busy, timeout_flag;
  logic [STG_W-1:0] stage_idx;
  logic [15:0]      seq_trig_count;

  int checks = 0;
  int failures = 0;
  int exp_seq_count = 0;

  always #5 clk = ~clk;

  trigger_sequencer #(.NUM_STAGES(NS), .TO_W(24), .HO_W(16)) dut (
    .clk(clk), .rst_n_sync(rst_n_sync), .arm(arm), .abort(abort),
    .cfg_num_stages(cfg_num_stages), .cfg_stage(cfg_stage), .cfg_timeout(cfg_timeout),
    .cfg_holdoff(cfg_holdoff), .cfg_auto_rearm(cfg_auto_rearm), .trigger_out(trigger_out),
    .trg_cfg_enable(trg_cfg_enable), .trg_cfg_positive(trg_cfg_positive),
    .trg_cfg_type(trg_cfg_type), .trg_cfg_count1(trg_cfg_count1), .trg_cfg_count2(trg_cfg_count2),
    .trg_cfg_time_base(trg_cfg_time_base), .trg_cfg_longer_no_edge(trg_cfg_longer_no_edge),
    .seq_trig(seq_trig), .stage_idx(stage_idx), .busy(busy), .timeout_flag(timeout_flag),
    .seq_trig_count(seq_trig_count)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // trg_cfg_* must equal the spec field layout of the given slot
  task automatic check_cfg(input string tag, input int s);
    logic [23:0] w;
    w = cfg_stage[s*24 +: 24];
    check_val({tag, "_lne"}, trg_cfg_longer_no_edge, w[23]);
    check_val({tag, "_tb"},  trg_cfg_time_base, w[22:20]);
    check_val({tag, "_c2"},  trg_cfg_count2, w[19:12]);
    check_val({tag, "_c1"},  trg_cfg_count1, w[11:4]);
    check_val({tag, "_type"}, trg_cfg_type, w[3:1]);
    check_val({tag, "_pos"}, trg_cfg_positive, w[0]);
  endtask

  task automatic randomize_slots();
    for (int i = 0; i < NS; i++) cfg_stage[i*24 +: 24] = 24'($urandom);
  endtask

  task automatic check_count(input string tag);
`ifdef SEQ_TRIG_COUNT_EN
    check_val(tag, seq_trig_count, exp_seq_count);
`else
    check_val(tag, seq_trig_count, 0);
`endif
  endtask

  // Arm from IDLE; returns with the DUT in ARM and slot 0 loaded.
  task automatic do_arm(input int last, input int to, input int h);
    cfg_num_stages = STG_W'(last);
    cfg_timeout    = 24'(to);
    cfg_holdoff    = 16'(h);
    randomize_slots();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check_val("arm_busy", busy, 1);
    check_val("arm_en", trg_cfg_enable, 1);
    check_val("arm_stage", stage_idx, 0);
    check_val("arm_to_clr", timeout_flag, 0);
    tick();
    check_cfg("load0", 0);
  endtask

  // One trigger_out pulse of w clks for stage s. For a non-final stage, returns
  // on the clk the next slot has just been loaded.
  task automatic run_stage(input int s, input int last, input int w);
    repeat ($urandom_range(0, 4)) tick();
    trigger_out = 1'b1;
    tick();
    check_val("rise_seq", seq_trig, (s == last));
    check_val("rise_stage", stage_idx, (s == last) ? s : s + 1);
    if (s == last) exp_seq_count++;
    for (int i = 1; i < w; i++) begin
      tick();
      check_val("seq_1clk", seq_trig, 0);
      check_cfg("cfg_hold_high", s);
    end
    trigger_out = 1'b0;
    if (s != last) begin
      tick();
      check_cfg("cfg_wait_low", s);
      tick();
      check_cfg("cfg_next", s + 1);
      check_val("en_kept", trg_cfg_enable, 1);
    end
  endtask

  // Holdoff after the final stage: completion exactly h clks after the first
  // clk that sees trigger_out low.
  task automatic holdoff_phase(input int h, input bit re);
    bit pulse;
    pulse = (h >= 6) && ($urandom_range(0, 1) == 1);
    randomize_slots();
    for (int j = 1; j <= h; j++) begin
      tick();
      check_val("ho_busy", busy, 1);
      check_val("ho_no_seq", seq_trig, 0);
      if (pulse && j == 2) trigger_out = 1'b1;
      if (pulse && j == 4) trigger_out = 1'b0;
    end
    tick();
    check_val("ho_done_busy", busy, re);
    check_val("ho_done_en", trg_cfg_enable, re);
    check_val("ho_done_stage", stage_idx, 0);
    check_val("ho_done_seq", seq_trig, 0);
    if (re) begin
      tick();
      check_cfg("rearm_load0", 0);
    end
  endtask

  task automatic run_full(input int last, input int h, input bit rearm);
    int passes;
    passes = rearm ? 2 : 1;
    for (int p = 0; p < passes; p++) begin
      cfg_auto_rearm = (p == 0) && rearm;
      // latched at arm: live changes must not matter
      cfg_num_stages = STG_W'($urandom);
      cfg_timeout    = 24'($urandom_range(1, 5));
      cfg_holdoff    = 16'($urandom);
      for (int s = 0; s <= last; s++) run_stage(s, last, $urandom_range(1, 8));
      holdoff_phase(h, cfg_auto_rearm);
    end
  endtask

  task automatic run_timeout(input int last, input int t, input bit race);
    do_arm(last, t, 0);
    run_stage(0, last, $urandom_range(1, 8));
    for (int k = 1; k < t; k++) begin
      tick();
      check_val("to_pending_flag", timeout_flag, 0);
      check_val("to_pending_stage", stage_idx, 1);
    end
    if (race) begin
      trigger_out = 1'b1;
      tick();
      check_val("race_flag", timeout_flag, 0);
      check_val("race_stage", stage_idx, (last == 1) ? 1 : 2);
      check_val("race_seq", seq_trig, (last == 1));
      if (last == 1) exp_seq_count++;
      trigger_out = 1'b0;
    end else begin
      tick();
      check_val("to_flag", timeout_flag, 1);
      check_val("to_stage", stage_idx, 0);
      check_val("to_busy", busy, 1);
      check_val("to_en", trg_cfg_enable, 1);
      tick();
      tick();
      check_cfg("to_reload0", 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_val("to_flag_sticky", timeout_flag, 1);
      arm = 1'b1;
      tick();
      arm = 1'b0;
      check_val("to_flag_clr_arm", timeout_flag, 0);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("to_abort_busy", busy, 0);
  endtask

  initial begin
    int last, h;
    repeat (2) tick();
    check_val("rst_busy", busy, 0);
    check_val("rst_en", trg_cfg_enable, 0);
    check_val("rst_stage", stage_idx, 0);
    check_val("rst_seq", seq_trig, 0);
    check_val("rst_to", timeout_flag, 0);
    check_val("rst_type", trg_cfg_type, 0);
    check_count("rst_count");
    rst_n_sync = 1'b1;
    tick();

    // single-stage sequence, no rearm
    h = $urandom_range(0, 12);
    do_arm(0, 0, h);
    run_full(0, h, 1'b0);

    for (int it = 0; it < 12; it++) begin
      last = $urandom_range(0, 3);
      h = $urandom_range(0, 20);
      do_arm(last, 0, h);
      run_full(last, h, $urandom_range(0, 1) == 1);
    end

    for (int it = 0; it < 6; it++)
      run_timeout($urandom_range(1, 3), $urandom_range(1, 40), it % 3 == 2);

    // arm and abort together: abort wins
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    check_val("armabort_busy", busy, 0);
    check_val("armabort_en", trg_cfg_enable, 0);
    tick();
    check_val("armabort_seq", seq_trig, 0);

    // abort while armed on stage 1, then an idle pulse is ignored
    do_arm(2, 0, 0);
    run_stage(0, 2, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("abort_arm_busy", busy, 0);
    check_val("abort_arm_stage", stage_idx, 0);
    check_val("abort_arm_en", trg_cfg_enable, 0);
    trigger_out = 1'b1;
    tick();
    tick();
    check_val("idle_pulse_seq", seq_trig, 0);
    check_val("idle_pulse_busy", busy, 0);
    trigger_out = 1'b0;
    tick();

    // abort during holdoff overrides auto-rearm
    cfg_auto_rearm = 1'b1;
    do_arm(0, 0, 30);
    run_stage(0, 0, 2);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("abort_ho_busy", busy, 0);
    check_val("abort_ho_en", trg_cfg_enable, 0);
    repeat (32) tick();
    check_val("abort_ho_stays", busy, 0);
    cfg_auto_rearm = 1'b0;
    check_count("count_before_rst");

    // asynchronous reset mid-sequence
    do_arm(3, 0, 0);
    run_stage(0, 3, 2);
    run_stage(1, 3, 2);
    #2;
    rst_n_sync = 1'b0;
    #2;
    exp_seq_count = 0;
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_en", trg_cfg_enable, 0);
    check_val("mid_rst_stage", stage_idx, 0);
    check_val("mid_rst_c1", trg_cfg_count1, 0);
    check_count("mid_rst_count");
    tick();
    rst_n_sync = 1'b1;
    tick();
    check_val("post_rst_busy", busy, 0);
    do_arm(0, 0, 3);
    run_full(0, 3, 1'b0);
    check_count("count_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
